// File: rtl/risc16_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : risc16_mem_pkg
// Brief    : Shared types and helpers for the RISC16 unified memory block
//            (loader state encoding, store lane masks, byte->word mapping).
// Revision : 1.0 - initial release
// ============================================================================
package risc16_mem_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // d_we lane masks: bit0 writes the even (high) byte, bit1 the odd (low) byte
  localparam logic [1:0] LANE_EVEN = 2'b01;
  localparam logic [1:0] LANE_ODD  = 2'b10;
  localparam logic [1:0] LANE_WORD = 2'b11;

  // Byte address to word index; callers keep only the low AW bits (wraps)
  function automatic logic [14:0] word_index(input logic [15:0] byte_addr);
    return byte_addr[15:1];
  endfunction

endpackage : risc16_mem_pkg
`default_nettype wire

// File: rtl/risc16_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Brief    : Host image loader. Holds the core in reset, streams host words
//            into memory from word 0, then releases the core.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader
  import risc16_mem_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic          ld_last,
  input  logic [15:0]   ld_data,
  output logic          ld_ready,
  output logic          cpu_rst,
  output logic [AW:0]   ld_count,
  output logic          ld_ovf,
  output state_t        state,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data
);

  state_t state_q;
  state_t state_d;
  logic   at_end;

  assign state   = state_q;
  assign at_end  = (ld_count[AW-1:0] == {AW{1'b1}});
  assign wr_addr = ld_count[AW-1:0];
  assign wr_data = ld_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HOLD;
    else     state_q <= state_d;
  end

  // Next state, ready handshake and load write strobe
  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      HOLD: begin
        if (ld_start) state_d = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          wr_en = 1'b1;
          if (ld_last || at_end) state_d = RUN;
        end
      end
      RUN: begin
        if (ld_start) state_d = LOAD;
      end
      default: state_d = HOLD;
    endcase
  end

  // Beat counter, overflow flag and registered core reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_count <= '0;
      ld_ovf   <= 1'b0;
      cpu_rst  <= 1'b1;
    end else begin
      cpu_rst <= (state_d != RUN);
      if (ld_start && (state_q != LOAD)) begin
        ld_count <= '0;
        ld_ovf   <= 1'b0;
      end else if (wr_en) begin
        ld_count <= ld_count + (AW+1)'(1);
        if (!ld_last && at_end) ld_ovf <= 1'b1;
      end
    end
  end

endmodule : mem_loader
`default_nettype wire

// File: rtl/risc16_mem.sv
`default_nettype none
// ============================================================================
// Module   : risc16_mem
// Brief    : Unified RISC16 instruction/data memory with combinational read
//            ports, byte-lane core stores and a host image load port.
//            Optional: define RISC16_MEM_WPROT_EN to make the loaded image
//            read-only to the core (violations flagged on wp_err).
// Revision : 1.0 - initial release
// ============================================================================
module risc16_mem
  import risc16_mem_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic        i_oe,
  output logic [15:0] i_din,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  output logic [15:0] d_din,
  input  logic [15:0] d_dout,
  input  logic [1:0]  d_we,
  input  logic        ld_start,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        cpu_rst,
  output logic [AW:0] ld_count,
  output logic        ld_ovf,
  output logic        wp_err
);

  logic [15:0]   mem [2**AW];
  state_t        ld_state;
  logic          ld_wr;
  logic [AW-1:0] ld_waddr;
  logic [15:0]   ld_wdata;
  logic [14:0]   i_idx_full;
  logic [14:0]   d_idx_full;
  logic [AW-1:0] i_idx;
  logic [AW-1:0] d_idx;
  logic          wp_hit;
  logic          core_wr;
  logic          unused_bits;

  mem_loader #(.AW(AW)) u_loader (
    .clk      (clk),
    .rst      (rst),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_last  (ld_last),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .cpu_rst  (cpu_rst),
    .ld_count (ld_count),
    .ld_ovf   (ld_ovf),
    .state    (ld_state),
    .wr_en    (ld_wr),
    .wr_addr  (ld_waddr),
    .wr_data  (ld_wdata)
  );

  // High address bits are dropped on purpose so addresses wrap
  assign i_idx_full  = word_index(i_addr);
  assign d_idx_full  = word_index(d_addr);
  assign i_idx       = i_idx_full[AW-1:0];
  assign d_idx       = d_idx_full[AW-1:0];
  assign unused_bits = ^{i_addr, d_addr, i_idx_full, d_idx_full};

  assign i_din = i_oe ? mem[i_idx] : 16'h0000;
  assign d_din = d_oe ? mem[d_idx] : 16'h0000;

`ifdef RISC16_MEM_WPROT_EN
  logic wp_err_q;

  assign wp_hit = (ld_state == RUN) && (d_we != 2'b00) &&
                  ({1'b0, d_idx} < ld_count);
  assign wp_err = wp_err_q;

  // Sticky protection violation flag, cleared when a new load begins
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  wp_err_q <= 1'b0;
    else if (ld_start && (ld_state != LOAD))  wp_err_q <= 1'b0;
    else if (wp_hit)                          wp_err_q <= 1'b1;
  end
`else
  assign wp_hit = 1'b0;
  assign wp_err = 1'b0;
`endif

  assign core_wr = (ld_state == RUN) && !wp_hit;

  // Array write: loader beats, or core byte-lane stores while running
  always_ff @(posedge clk) begin
    if (ld_wr) begin
      mem[ld_waddr] <= ld_wdata;
    end else if (core_wr) begin
      if ((d_we & LANE_EVEN) != 2'b00) mem[d_idx][15:8] <= d_dout[15:8];
      if ((d_we & LANE_ODD)  != 2'b00) mem[d_idx][7:0]  <= d_dout[7:0];
    end
  end

endmodule : risc16_mem
`default_nettype wire

// File: tb/tb_risc16_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc16_mem
// Brief    : Directed self-checking bench for risc16_mem (AW=12 main instance
//            plus an AW=3 instance for image overflow).
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc16_mem;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  // Main instance (AW = 12)
  logic [15:0] i_addr, d_addr, d_dout, ld_data, i_din, d_din;
  logic        i_oe, d_oe, ld_start, ld_valid, ld_last;
  logic [1:0]  d_we;
  logic        ld_ready, cpu_rst, ld_ovf, wp_err;
  logic [12:0] ld_count;

  // Small instance (AW = 3)
  logic [15:0] s_i_addr, s_d_addr, s_d_dout, s_ld_data, s_i_din, s_d_din;
  logic        s_i_oe, s_d_oe, s_ld_start, s_ld_valid, s_ld_last;
  logic [1:0]  s_d_we;
  logic        s_ld_ready, s_cpu_rst, s_ld_ovf, s_wp_err;
  logic [3:0]  s_ld_count;

  always #5 clk = ~clk;

  risc16_mem #(.AW(12)) u_dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_oe(i_oe), .i_din(i_din),
    .d_addr(d_addr), .d_oe(d_oe), .d_din(d_din), .d_dout(d_dout), .d_we(d_we),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .cpu_rst(cpu_rst),
    .ld_count(ld_count), .ld_ovf(ld_ovf), .wp_err(wp_err)
  );

  risc16_mem #(.AW(3)) u_small (
    .clk(clk), .rst(rst),
    .i_addr(s_i_addr), .i_oe(s_i_oe), .i_din(s_i_din),
    .d_addr(s_d_addr), .d_oe(s_d_oe), .d_din(s_d_din), .d_dout(s_d_dout), .d_we(s_d_we),
    .ld_start(s_ld_start), .ld_valid(s_ld_valid), .ld_ready(s_ld_ready),
    .ld_data(s_ld_data), .ld_last(s_ld_last), .cpu_rst(s_cpu_rst),
    .ld_count(s_ld_count), .ld_ovf(s_ld_ovf), .wp_err(s_wp_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_addr = '0; i_oe = 0; d_addr = '0; d_oe = 0; d_dout = '0; d_we = '0;
    ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
    s_i_addr = '0; s_i_oe = 0; s_d_addr = '0; s_d_oe = 0; s_d_dout = '0; s_d_we = '0;
    s_ld_start = 0; s_ld_valid = 0; s_ld_last = 0; s_ld_data = '0;
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got %b exp 1", cpu_rst); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got %b exp 0", ld_ready); end
    checks++; if (ld_count !== 13'd0) begin errors++; $display("FAIL reset_ld_count got %0d exp 0", ld_count); end
    checks++; if (ld_ovf !== 1'b0) begin errors++; $display("FAIL reset_ld_ovf got %b exp 0", ld_ovf); end
    checks++; if (wp_err !== 1'b0) begin errors++; $display("FAIL reset_wp_err got %b exp 0", wp_err); end
    checks++; if (i_din !== 16'h0000) begin errors++; $display("FAIL reset_i_din_gated got %h exp 0000", i_din); end
    checks++; if (d_din !== 16'h0000) begin errors++; $display("FAIL reset_d_din_gated got %h exp 0000", d_din); end
  endtask

  task automatic test_load4();
    logic [15:0] words [4];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b exp 1", ld_ready); end
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b0;
      step();
      ld_valid = 1'b1;
      ld_data  = words[i];
      ld_last  = (i == 3);
      #1;
      checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL load_cpu_rst_held beat %0d got %b exp 1", i, cpu_rst); end
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      if (i == 1) begin
        checks++; if (ld_count !== 13'd2) begin errors++; $display("FAIL load_count_mid got %0d exp 2", ld_count); end
      end
    end
    checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL load_cpu_rst_release got %b exp 0", cpu_rst); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL load_ready_run got %b exp 0", ld_ready); end
    checks++; if (ld_count !== 13'd4) begin errors++; $display("FAIL load_count got %0d exp 4", ld_count); end
    i_oe = 1'b1; i_addr = 16'h0004; #1;
    checks++; if (i_din !== 16'h3333) begin errors++; $display("FAIL load_ifetch got %h exp 3333", i_din); end
    i_addr = 16'h2005; #1;
    checks++; if (i_din !== 16'h3333) begin errors++; $display("FAIL load_ifetch_wrap got %h exp 3333", i_din); end
    i_oe = 1'b0; #1;
    checks++; if (i_din !== 16'h0000) begin errors++; $display("FAIL load_ifetch_gated got %h exp 0000", i_din); end
  endtask

  task automatic test_byte_store();
    d_addr = 16'h0010; d_we = 2'b11; d_dout = 16'h1234;
    step();
    d_we = 2'b01; d_dout = 16'hAB00;
    step();
    d_we = 2'b00; d_oe = 1'b1; #1;
    checks++; if (d_din !== 16'hAB34) begin errors++; $display("FAIL store_even_lane got %h exp AB34", d_din); end
    d_addr = 16'h0011; d_we = 2'b10; d_dout = 16'h00CD; #1;
    checks++; if (d_din !== 16'hAB34) begin errors++; $display("FAIL store_same_cycle_old got %h exp AB34", d_din); end
    step();
    d_we = 2'b00; #1;
    checks++; if (d_din !== 16'hABCD) begin errors++; $display("FAIL store_odd_lane got %h exp ABCD", d_din); end
    i_oe = 1'b1; i_addr = 16'h0010; #1;
    checks++; if (i_din !== 16'hABCD) begin errors++; $display("FAIL store_ifetch_view got %h exp ABCD", i_din); end
    i_oe = 1'b0;
  endtask

  task automatic test_wprot();
    logic [15:0] exp_w1;
    logic        exp_err;
`ifdef RISC16_MEM_WPROT_EN
    exp_w1 = 16'h2222; exp_err = 1'b1;
`else
    exp_w1 = 16'hDEAD; exp_err = 1'b0;
`endif
    d_addr = 16'h0002; d_we = 2'b11; d_dout = 16'hDEAD;
    step();
    d_we = 2'b00; d_oe = 1'b1; #1;
    checks++; if (d_din !== exp_w1) begin errors++; $display("FAIL wprot_inside got %h exp %h", d_din, exp_w1); end
    checks++; if (wp_err !== exp_err) begin errors++; $display("FAIL wprot_err got %b exp %b", wp_err, exp_err); end
    d_addr = 16'h0008; d_we = 2'b11; d_dout = 16'h5555;
    step();
    d_we = 2'b00; #1;
    checks++; if (d_din !== 16'h5555) begin errors++; $display("FAIL wprot_boundary got %h exp 5555", d_din); end
  endtask

  task automatic test_reload();
    d_addr = 16'h0010; d_we = 2'b11; d_dout = 16'hFFFF; ld_start = 1'b1; #1;
    checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL reload_before_edge got %b exp 0", cpu_rst); end
    step();
    ld_start = 1'b0; d_dout = 16'h0000;
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reload_cpu_rst got %b exp 1", cpu_rst); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reload_ready got %b exp 1", ld_ready); end
    checks++; if (ld_count !== 13'd0) begin errors++; $display("FAIL reload_count_clr got %0d exp 0", ld_count); end
    checks++; if (wp_err !== 1'b0) begin errors++; $display("FAIL reload_wp_clr got %b exp 0", wp_err); end
    repeat (2) step();
    d_we = 2'b00; d_oe = 1'b1; #1;
    checks++; if (d_din !== 16'hFFFF) begin errors++; $display("FAIL reload_store_blocked got %h exp FFFF", d_din); end
    ld_valid = 1'b1; ld_data = 16'h0A0A; ld_last = 1'b0;
    step();
    ld_valid = 1'b0; ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    checks++; if (ld_count !== 13'd1) begin errors++; $display("FAIL reload_start_ignored got %0d exp 1", ld_count); end
    ld_valid = 1'b1; ld_data = 16'h0B0B; ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL reload_release got %b exp 0", cpu_rst); end
    checks++; if (ld_count !== 13'd2) begin errors++; $display("FAIL reload_count got %0d exp 2", ld_count); end
    i_oe = 1'b1; i_addr = 16'h0002; #1;
    checks++; if (i_din !== 16'h0B0B) begin errors++; $display("FAIL reload_word1 got %h exp 0B0B", i_din); end
    i_oe = 1'b0;
  endtask

  task automatic test_overflow();
    s_ld_start = 1'b1;
    step();
    s_ld_start = 1'b0; s_ld_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_ld_data = 16'h0100 + 16'(i);
      if (i == 7) begin
        #1;
        checks++; if (s_ld_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", s_ld_ovf); end
      end
      step();
    end
    checks++; if (s_ld_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", s_ld_ovf); end
    checks++; if (s_ld_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", s_ld_count); end
    checks++; if (s_cpu_rst !== 1'b0) begin errors++; $display("FAIL ovf_run got %b exp 0", s_cpu_rst); end
    checks++; if (s_ld_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got %b exp 0", s_ld_ready); end
    s_ld_data = 16'h0999;
    step();
    s_ld_valid = 1'b0;
    checks++; if (s_ld_count !== 4'd8) begin errors++; $display("FAIL ovf_ninth_count got %0d exp 8", s_ld_count); end
    s_i_oe = 1'b1; s_i_addr = 16'h0010; #1;
    checks++; if (s_i_din !== 16'h0100) begin errors++; $display("FAIL ovf_word0_wrap got %h exp 0100", s_i_din); end
    s_i_addr = 16'h000E; #1;
    checks++; if (s_i_din !== 16'h0107) begin errors++; $display("FAIL ovf_word7 got %h exp 0107", s_i_din); end
    s_ld_start = 1'b1;
    step();
    s_ld_start = 1'b0;
    checks++; if (s_ld_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", s_ld_ovf); end
    checks++; if (s_cpu_rst !== 1'b1) begin errors++; $display("FAIL ovf_rehold got %b exp 1", s_cpu_rst); end
  endtask

  task automatic test_async_reset();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 16'h7777; ld_last = 1'b0;
    step();
    ld_valid = 1'b0;
    checks++; if (ld_count !== 13'd1) begin errors++; $display("FAIL areset_pre_count got %0d exp 1", ld_count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL areset_cpu_rst got %b exp 1", cpu_rst); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL areset_ready got %b exp 0", ld_ready); end
    checks++; if (ld_count !== 13'd0) begin errors++; $display("FAIL areset_count got %0d exp 0", ld_count); end
    step();
    rst = 1'b0;
    step();
    i_oe = 1'b1; i_addr = 16'h0000; #1;
    checks++; if (i_din !== 16'h7777) begin errors++; $display("FAIL areset_word0 got %h exp 7777", i_din); end
    i_addr = 16'h0002; #1;
    checks++; if (i_din !== 16'h0B0B) begin errors++; $display("FAIL areset_word1 got %h exp 0B0B", i_din); end
  endtask

  initial begin
    test_reset();
    test_load4();
    test_byte_store();
    test_wprot();
    test_reload();
    test_overflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_risc16_mem
`default_nettype wire
